// File: rtl/move_pkg.sv
// move_pkg: screen/sprite geometry and vertical-motion state shared by the fire
// character controller and the sprite-drawing stage.
`default_nettype none
package move_pkg;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } move_state_t;

  localparam int SCREEN_W     = 1024;
  localparam int SCREEN_H     = 768;
  localparam int SPRITE_SRC   = 26;
  localparam int SPRITE_SCALE = 2;
  localparam int SPRITE_DIM   = SPRITE_SRC * SPRITE_SCALE;

  // Saturate a signed 13-bit candidate position into [lo, hi].
  function automatic logic signed [12:0] clamp13(input logic signed [12:0] v,
                                                 input logic signed [12:0] lo,
                                                 input logic signed [12:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fire_move_ctl_if.sv
// fire_move_if: player inputs, frame sync and sprite position bundle.
`default_nettype none
interface fire_move_if;
  logic        vsync;
  logic        left;
  logic        right;
  logic        jump;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  logic        airborne;

  modport master (output vsync, left, right, jump,
                  input  pos_x, pos_y, airborne);
  modport slave  (input  vsync, left, right, jump,
                  output pos_x, pos_y, airborne);
endinterface
`default_nettype wire

// File: rtl/edge_rise.sv
// edge_rise: registered one-cycle pulse on each rising edge of sig.
`default_nettype none
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);
  logic sig_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_d <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sig_d <= sig;
      pulse <= sig & ~sig_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/fire_move_ctl.sv
// fire_move_ctl: once-per-frame position update (walk, jump, gravity, clamping).
// Define FIRE_DOUBLE_JUMP_EN to allow one extra mid-air jump per airtime.
`default_nettype none
module fire_move_ctl
  import move_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = SCREEN_W,
  parameter int Y_MIN    = 0,
  parameter int SPRITE_W = SPRITE_DIM,
  parameter int SPRITE_H = SPRITE_DIM,
  parameter int FLOOR_Y  = SCREEN_H - SPRITE_H,
  parameter int X_START  = 100,
  parameter int H_SPEED  = 4,
  parameter int JUMP_V0  = 16,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 16
) (
  input  logic        clk,
  input  logic        rst,
  fire_move_if.slave  bus
);
  localparam logic signed [12:0] X_LO  = 13'(X_MIN);
  localparam logic signed [12:0] X_HI  = 13'(X_MAX - SPRITE_W);
  localparam logic signed [12:0] Y_LO  = 13'(Y_MIN);
  localparam logic signed [12:0] Y_FL  = 13'(FLOOR_Y);
  localparam logic signed [12:0] H_SPD = 13'(H_SPEED);
  localparam logic [5:0]         V0    = 6'(JUMP_V0);
  localparam logic [5:0]         G     = 6'(GRAVITY);
  localparam logic [6:0]         VMAX7 = 7'(V_MAX);

  logic        tick;
  logic        jump_rise;
  logic        jump_req;
  move_state_t state, state_nxt;
  logic [5:0]  vel, vel_nxt;
  logic [6:0]  vel_inc;
  logic [11:0] x_pos, y_pos;
  logic signed [12:0] x_try, x_nxt, y_try, y_nxt;

  edge_rise u_vsync_edge (.clk(clk), .rst(rst), .sig(bus.vsync), .pulse(tick));
  edge_rise u_jump_edge  (.clk(clk), .rst(rst), .sig(bus.jump),  .pulse(jump_rise));

  always_comb begin
    x_try = $signed({1'b0, x_pos});
    if (bus.left && !bus.right)      x_try = x_try - H_SPD;
    else if (bus.right && !bus.left) x_try = x_try + H_SPD;
    x_nxt = clamp13(x_try, X_LO, X_HI);
  end

`ifdef FIRE_DOUBLE_JUMP_EN
  logic used_dj, used_dj_nxt;
`endif

  always_comb begin
    state_nxt = state;
    vel_nxt   = vel;
    y_nxt     = $signed({1'b0, y_pos});
    y_try     = $signed({1'b0, y_pos});
    vel_inc   = {1'b0, vel} + {1'b0, G};
    unique case (state)
      GROUND: begin
        if (jump_req) begin
          vel_nxt   = V0;
          state_nxt = RISING;
        end
      end
      RISING: begin
        y_try = $signed({1'b0, y_pos}) - $signed({7'd0, vel});
        if (y_try < Y_LO) begin
          y_nxt     = Y_LO;
          vel_nxt   = 6'd0;
          state_nxt = FALLING;
        end else begin
          y_nxt   = y_try;
          vel_nxt = vel - G;
          if (vel_nxt == 6'd0) state_nxt = FALLING;
        end
      end
      FALLING: begin
        vel_nxt = (vel_inc > VMAX7) ? VMAX7[5:0] : vel_inc[5:0];
        y_try   = $signed({1'b0, y_pos}) + $signed({7'd0, vel_nxt});
        if (y_try >= Y_FL) begin
          y_nxt     = Y_FL;
          vel_nxt   = 6'd0;
          state_nxt = GROUND;
        end else begin
          y_nxt = y_try;
        end
      end
      default: begin
        state_nxt = GROUND;
        vel_nxt   = 6'd0;
        y_nxt     = Y_FL;
      end
    endcase
`ifdef FIRE_DOUBLE_JUMP_EN
    // Mid-air jump relaunches from the current height, once per airtime.
    used_dj_nxt = used_dj;
    if (state != GROUND && jump_req && !used_dj) begin
      vel_nxt     = V0;
      state_nxt   = RISING;
      y_nxt       = $signed({1'b0, y_pos});
      used_dj_nxt = 1'b1;
    end
    if (state_nxt == GROUND) used_dj_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GROUND;
      vel      <= 6'd0;
      x_pos    <= 12'(X_START);
      y_pos    <= 12'(FLOOR_Y);
      jump_req <= 1'b0;
`ifdef FIRE_DOUBLE_JUMP_EN
      used_dj  <= 1'b0;
`endif
    end else if (tick) begin
      state    <= state_nxt;
      vel      <= vel_nxt;
      x_pos    <= x_nxt[11:0];
      y_pos    <= y_nxt[11:0];
      // A press landing on the tick itself is kept for the following frame.
      jump_req <= jump_rise;
`ifdef FIRE_DOUBLE_JUMP_EN
      used_dj  <= used_dj_nxt;
`endif
    end else if (jump_rise) begin
      jump_req <= 1'b1;
    end
  end

  assign bus.pos_x    = x_pos;
  assign bus.pos_y    = y_pos;
  assign bus.airborne = (state != GROUND);
endmodule
`default_nettype wire

// File: tb/tb_fire_move_ctl.sv
// tb_fire_move_ctl: randomized frame stimulus, per-frame reference model and scoreboard.
`default_nettype none
module tb_fire_move_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fire_move_if bus ();
  fire_move_ctl dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef FIRE_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  typedef struct {
    int x;
    int y;
    bit air;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: position, velocity magnitude and flight phase.
  int mx, my, mvel;
  bit m_air, m_up, m_dj, m_jreq, jprev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 100; my = 716; mvel = 0;
    m_air = 0; m_up = 0; m_dj = 0; m_jreq = 0;
  endtask

  task automatic model_tick(input bit l, input bit r);
    if (l && !r)      mx = (mx - 4 < 0)   ? 0   : mx - 4;
    else if (r && !l) mx = (mx + 4 > 972) ? 972 : mx + 4;
    if (!m_air) begin
      if (m_jreq) begin m_air = 1; m_up = 1; mvel = 16; end
    end else if (DJ && m_jreq && !m_dj) begin
      m_up = 1; mvel = 16; m_dj = 1;
    end else if (m_up) begin
      if (my - mvel < 0) begin my = 0; mvel = 0; m_up = 0; end
      else begin
        my = my - mvel;
        mvel = mvel - 1;
        if (mvel == 0) m_up = 0;
      end
    end else begin
      mvel = (mvel + 1 > 16) ? 16 : mvel + 1;
      my = my + mvel;
      if (my >= 716) begin my = 716; mvel = 0; m_air = 0; m_dj = 0; end
    end
    m_jreq = 0;
  endtask

  // One video frame: inputs settle, then a two-cycle vsync pulse.
  task automatic frame(input bit l, input bit r, input bit j);
    bus.left = l; bus.right = r; bus.jump = j;
    if (j && !jprev) m_jreq = 1;
    jprev = j;
    repeat (6) @(negedge clk);
    model_tick(l, r);
    q.push_back('{mx, my, m_air});
    bus.vsync = 1'b1;
    repeat (2) @(negedge clk);
    bus.vsync = 1'b0;
  endtask

  task automatic reset_midair();
    #3 rst = 1'b1;
    #1;
    check("async_rst_x",   bus.pos_x,    100);
    check("async_rst_y",   bus.pos_y,    716);
    check("async_rst_air", bus.airborne, 0);
    model_reset();
    bus.jump = 1'b0; jprev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: outputs update on the second edge after vsync is first seen high.
  bit vs_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.vsync && !vs_prev && !rst) begin
        vs_prev = 1'b1;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          check("pos_x",    bus.pos_x,    e.x);
          check("pos_y",    bus.pos_y,    e.y);
          check("airborne", bus.airborne, e.air);
        end
      end else begin
        vs_prev = bus.vsync;
      end
    end
  end

  initial begin
    bus.vsync = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.jump = 1'b0;
    jprev = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_x",   bus.pos_x,    100);
    check("reset_y",   bus.pos_y,    716);
    check("reset_air", bus.airborne, 0);
    rst = 1'b0;

    repeat (3) frame(0, 1, 0);
    repeat (2) frame(1, 1, 0);
    repeat (2) frame(0, 0, 0);

    // Single jump, jump held long past landing.
    repeat (40) frame(0, 0, 1);
    frame(0, 0, 0);

    // Pulse at takeoff, at the apex, then once more while airborne.
    frame(0, 0, 1);
    repeat (15) frame(0, 0, 0);
    frame(0, 0, 1);
    repeat (3) frame(0, 0, 0);
    frame(1, 0, 1);
    repeat (45) frame(0, 0, 0);
    frame(0, 0, 1);
    repeat (40) frame(0, 0, 0);

    // Reset while airborne.
    frame(0, 1, 1);
    repeat (5) frame(0, 1, 0);
    reset_midair();

    // Saturate right and left, jumping along the way.
    for (int i = 0; i < 235; i++) frame(0, 1, (i % 50) == 7);
    for (int i = 0; i < 255; i++) frame(1, 0, (i % 60) == 3);

    for (int i = 0; i < 200; i++) begin
      bit l, r, j;
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 5) == 0);
      frame(l, r, j);
    end

    repeat (4) @(negedge clk);
    if (q.size() != 0) check("scoreboard_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
